bbox_overlay: RTL and testbench

- Video stage placed directly downstream of the per-channel LUT colour-mapping stage.
- Takes the mapped 24-bit RGB stream with its DE/HSYNC/VSYNC and classifies each active pixel as foreground by a red-channel threshold.
- Tracks the foreground bounding box over each frame and latches it at frame end.
- Draws that rectangle in a fixed colour over the following frame's video; the stream passes on with 1-cycle latency.

---
 rtl/bbox_overlay.sv | 199 +++++++++++++++++++
 tb/tb_bbox_overlay.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bbox_overlay.sv
// Foreground bounding-box tracker with outline overlay, 1-cycle video latency.
// Optional BBOX_CROSSHAIR_EN adds a centre crosshair inside the latched box.
module bbox_overlay #(
  parameter logic [7:0]  THRESHOLD = 8'd128,
  parameter int          X_W       = 11,
  parameter int          Y_W       = 11,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           de_in,
  input  logic           h_sync_in,
  input  logic           v_sync_in,
  input  logic [23:0]    pixel_in,
  output logic           de_out,
  output logic           h_sync_out,
  output logic           v_sync_out,
  output logic [23:0]    pixel_out,
  output logic           box_valid,
  output logic [X_W-1:0] box_x_min,
  output logic [X_W-1:0] box_x_max,
  output logic [Y_W-1:0] box_y_min,
  output logic [Y_W-1:0] box_y_max
);

  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    return (&v) ? v : v + X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (&v) ? v : v + Y_W'(1);
  endfunction

  state_t         state_q, state_d;
  logic           de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [23:0]    pix_q, pix_d;
  logic [X_W-1:0] x_cnt_q, x_cnt_d;
  logic [Y_W-1:0] y_cnt_q, y_cnt_d;
  logic [X_W-1:0] acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
  logic [Y_W-1:0] acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
  logic           acc_hit_q, acc_hit_d;
  logic           box_valid_q, box_valid_d;
  logic [X_W-1:0] box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
  logic [Y_W-1:0] box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;

  logic           vs_rise, de_fall, fg, on_box;
  logic           x_edge, y_edge, x_in, y_in;
  logic [X_W-1:0] nx_min, nx_max;
  logic [Y_W-1:0] ny_min, ny_max;
  logic           n_hit;

`ifdef BBOX_CROSSHAIR_EN
  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic [X_W:0]   x_sum;
  logic [Y_W:0]   y_sum;
`endif

  always_comb begin
    // Edge detection reuses the output registers as the previous-cycle samples.
    vs_rise = v_sync_in & ~vs_q;
    de_fall = ~de_in & de_q;
    fg      = de_in & (pixel_in[23:16] >= THRESHOLD);

    x_cnt_d = de_in ? sat_inc_x(x_cnt_q) : '0;
    if (vs_rise)      y_cnt_d = '0;
    else if (de_fall) y_cnt_d = sat_inc_y(y_cnt_q);
    else              y_cnt_d = y_cnt_q;

    nx_min = acc_x_min_q;
    nx_max = acc_x_max_q;
    ny_min = acc_y_min_q;
    ny_max = acc_y_max_q;
    n_hit  = acc_hit_q;
    if (fg) begin
      if (x_cnt_q < acc_x_min_q) nx_min = x_cnt_q;
      if (x_cnt_q > acc_x_max_q) nx_max = x_cnt_q;
      if (y_cnt_q < acc_y_min_q) ny_min = y_cnt_q;
      if (y_cnt_q > acc_y_max_q) ny_max = y_cnt_q;
      n_hit = 1'b1;
    end

    state_d     = state_q;
    acc_x_min_d = nx_min;
    acc_x_max_d = nx_max;
    acc_y_min_d = ny_min;
    acc_y_max_d = ny_max;
    acc_hit_d   = n_hit;
    box_valid_d = box_valid_q;
    box_x_min_d = box_x_min_q;
    box_x_max_d = box_x_max_q;
    box_y_min_d = box_y_min_q;
    box_y_max_d = box_y_max_q;
`ifdef BBOX_CROSSHAIR_EN
    x_sum = {1'b0, nx_min} + {1'b0, nx_max};
    y_sum = {1'b0, ny_min} + {1'b0, ny_max};
    cx_d  = cx_q;
    cy_d  = cy_q;
`endif

    if (vs_rise) begin
      // The pixel coinciding with the frame boundary is folded in before the latch.
      if (state_q == ACTIVE) begin
        box_valid_d = n_hit;
        box_x_min_d = nx_min;
        box_x_max_d = nx_max;
        box_y_min_d = ny_min;
        box_y_max_d = ny_max;
`ifdef BBOX_CROSSHAIR_EN
        cx_d = x_sum[X_W:1];
        cy_d = y_sum[Y_W:1];
`endif
      end
      state_d     = ACTIVE;
      acc_x_min_d = '1;
      acc_x_max_d = '0;
      acc_y_min_d = '1;
      acc_y_max_d = '0;
      acc_hit_d   = 1'b0;
    end

    x_edge = (x_cnt_q == box_x_min_q) || (x_cnt_q == box_x_max_q);
    y_edge = (y_cnt_q == box_y_min_q) || (y_cnt_q == box_y_max_q);
    x_in   = (x_cnt_q >= box_x_min_q) && (x_cnt_q <= box_x_max_q);
    y_in   = (y_cnt_q >= box_y_min_q) && (y_cnt_q <= box_y_max_q);
`ifdef BBOX_CROSSHAIR_EN
    on_box = box_valid_q & de_in & ((x_edge & y_in) | (y_edge & x_in) |
                                    ((x_cnt_q == cx_q) & y_in) | ((y_cnt_q == cy_q) & x_in));
`else
    on_box = box_valid_q & de_in & ((x_edge & y_in) | (y_edge & x_in));
`endif

    de_d  = de_in;
    hs_d  = h_sync_in;
    vs_d  = v_sync_in;
    pix_d = on_box ? BOX_COLOR : pixel_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_FRAME;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      pix_q       <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      acc_x_min_q <= '1;
      acc_x_max_q <= '0;
      acc_y_min_q <= '1;
      acc_y_max_q <= '0;
      acc_hit_q   <= 1'b0;
      box_valid_q <= 1'b0;
      box_x_min_q <= '0;
      box_x_max_q <= '0;
      box_y_min_q <= '0;
      box_y_max_q <= '0;
`ifdef BBOX_CROSSHAIR_EN
      cx_q        <= '0;
      cy_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      pix_q       <= pix_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      acc_x_min_q <= acc_x_min_d;
      acc_x_max_q <= acc_x_max_d;
      acc_y_min_q <= acc_y_min_d;
      acc_y_max_q <= acc_y_max_d;
      acc_hit_q   <= acc_hit_d;
      box_valid_q <= box_valid_d;
      box_x_min_q <= box_x_min_d;
      box_x_max_q <= box_x_max_d;
      box_y_min_q <= box_y_min_d;
      box_y_max_q <= box_y_max_d;
`ifdef BBOX_CROSSHAIR_EN
      cx_q        <= cx_d;
      cy_q        <= cy_d;
`endif
    end
  end

  assign de_out     = de_q;
  assign h_sync_out = hs_q;
  assign v_sync_out = vs_q;
  assign pixel_out  = pix_q;
  assign box_valid  = box_valid_q;
  assign box_x_min  = box_x_min_q;
  assign box_x_max  = box_x_max_q;
  assign box_y_min  = box_y_min_q;
  assign box_y_max  = box_y_max_q;

endmodule

// File: tb/tb_bbox_overlay.sv
// Directed bench for bbox_overlay: 8x6 frames, 2-cycle blanking, v_sync pulse between frames.
module tb_bbox_overlay;
  logic        clk = 1'b0;
  logic        rst, de_in, h_sync_in, v_sync_in;
  logic [23:0] pixel_in;
  logic        de_out, h_sync_out, v_sync_out, box_valid;
  logic [23:0] pixel_out;
  logic [10:0] box_x_min, box_x_max, box_y_min, box_y_max;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  fg_r    [6][8];
  logic [23:0] out_pix [6][8];

  bbox_overlay dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .pixel_in(pixel_in), .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .pixel_out(pixel_out), .box_valid(box_valid), .box_x_min(box_x_min),
    .box_x_max(box_x_max), .box_y_min(box_y_min), .box_y_max(box_y_max)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] in_pix(input int x, input int y);
    return {fg_r[y][x], 8'(x * 16 + 1), 8'(y * 16 + 2)};
  endfunction

  function automatic bit exp_on(input int x, input int y, input int x0, input int x1,
                                input int y0, input int y1);
    bit xi, yi, hit;
    xi  = (x >= x0) && (x <= x1);
    yi  = (y >= y0) && (y <= y1);
    hit = ((x == x0 || x == x1) && yi) || ((y == y0 || y == y1) && xi);
`ifdef BBOX_CROSSHAIR_EN
    hit = hit || ((x == (x0 + x1) / 2) && yi) || ((y == (y0 + y1) / 2) && xi);
`endif
    return hit;
  endfunction

  task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] p);
    de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = p;
    @(posedge clk); #1;
    chk("de_out", de_out, de);
    chk("h_sync_out", h_sync_out, hs);
    chk("v_sync_out", v_sync_out, vs);
  endtask

  task automatic clear_fg();
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) fg_r[y][x] = 8'h00;
  endtask

  task automatic run_frame(input bit vs_last);
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        step(1'b1, 1'b0, (vs_last && y == 5 && x == 7), in_pix(x, y));
        out_pix[y][x] = pixel_out;
      end
      if (vs_last && y == 5) begin
        step(1'b0, 1'b0, 1'b1, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
      end else begin
        step(1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b1, 1'b0, 24'h0);
      end
    end
  endtask

  task automatic vsync_pulse();
    step(1'b0, 1'b0, 1'b1, 24'h0);
    step(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic check_frame(input string tag, input bit v, input int x0, input int x1,
                             input int y0, input int y1);
    logic [23:0] exp;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) begin
        exp = (v && exp_on(x, y, x0, x1, y0, y1)) ? 24'hFF0000 : in_pix(x, y);
        chk($sformatf("%s pix(%0d,%0d)", tag, x, y), out_pix[y][x], exp);
      end
  endtask

  task automatic check_box(input string tag, input bit v, input int x0, input int x1,
                           input int y0, input int y1);
    chk({tag, " box_valid"}, box_valid, v);
    chk({tag, " box_x_min"}, box_x_min, x0);
    chk({tag, " box_x_max"}, box_x_max, x1);
    chk({tag, " box_y_min"}, box_y_min, y0);
    chk({tag, " box_y_max"}, box_y_max, y1);
  endtask

  initial begin
    // Reset with live-looking inputs: every output must still read 0.
    rst = 1'b1; de_in = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b1; pixel_in = 24'hABCDEF;
    @(posedge clk); #1;
    chk("rst de_out", de_out, 0);
    chk("rst h_sync_out", h_sync_out, 0);
    chk("rst v_sync_out", v_sync_out, 0);
    chk("rst pixel_out", pixel_out, 0);
    check_box("rst", 0, 0, 0, 0, 0);
    rst = 1'b0; de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = 24'h0;
    @(posedge clk); #1;

    // Frame 1: partial first frame, discarded
    clear_fg(); fg_r[1][2] = 8'hC8;
    run_frame(1'b0);
    check_frame("f1", 0, 0, 0, 0, 0);
    vsync_pulse();
    check_box("f1 discard", 0, 0, 0, 0, 0);

    // Frame 2: two foreground pixels define the box
    clear_fg(); fg_r[1][2] = 8'hC8; fg_r[4][5] = 8'h80;
    run_frame(1'b0);
    check_frame("f2", 0, 0, 0, 0, 0);
    vsync_pulse();
    check_box("f2 latch", 1, 2, 5, 1, 4);

    // Frame 3: outline drawn, no foreground so the next latch is empty
    clear_fg();
    run_frame(1'b0);
    chk("f3 outline (2,1)", out_pix[1][2], 24'hFF0000);
    chk("f3 outline (5,3)", out_pix[3][5], 24'hFF0000);
    chk("f3 outline (3,4)", out_pix[4][3], 24'hFF0000);
    chk("f3 pass (3,2)", out_pix[2][3], in_pix(3, 2));
    check_frame("f3", 1, 2, 5, 1, 4);
    vsync_pulse();
    check_box("f3 empty", 0, 2047, 0, 2047, 0);

    // Frame 4: R=127 is below threshold; no overlay from the empty box
    clear_fg(); fg_r[0][0] = 8'd127;
    run_frame(1'b0);
    check_frame("f4", 0, 0, 0, 0, 0);
    vsync_pulse();
    check_box("f4 r127", 0, 2047, 0, 2047, 0);

    // Frame 5: R=128 is exactly the threshold
    clear_fg(); fg_r[0][0] = 8'd128;
    run_frame(1'b0);
    check_frame("f5", 0, 0, 0, 0, 0);
    vsync_pulse();
    check_box("f5 r128", 1, 0, 0, 0, 0);

    // Frame 6: single-pixel overlay; foreground for a 2..6 x 1..5 box
    clear_fg(); fg_r[1][2] = 8'd200; fg_r[5][6] = 8'd255;
    run_frame(1'b0);
    chk("f6 single (0,0)", out_pix[0][0], 24'hFF0000);
    check_frame("f6", 1, 0, 0, 0, 0);
    vsync_pulse();
    check_box("f6 latch", 1, 2, 6, 1, 5);

    // Frame 7: outline (plus crosshair at column 4 / row 3 when enabled)
    run_frame(1'b0);
`ifdef BBOX_CROSSHAIR_EN
    chk("f7 cross (4,2)", out_pix[2][4], 24'hFF0000);
    chk("f7 cross (3,3)", out_pix[3][3], 24'hFF0000);
`else
    chk("f7 inner (4,2)", out_pix[2][4], in_pix(4, 2));
`endif
    check_frame("f7", 1, 2, 6, 1, 5);
    vsync_pulse();
    check_box("f7 latch", 1, 2, 6, 1, 5);

    // Frame 8: reset mid-frame at (0,3)
    clear_fg(); fg_r[4][3] = 8'd200;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 8; x++) step(1'b1, 1'b0, 1'b0, in_pix(x, y));
      step(1'b0, 1'b1, 1'b0, 24'h0);
      step(1'b0, 1'b1, 1'b0, 24'h0);
    end
    rst = 1'b1; de_in = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = 24'h123456;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst box_valid", box_valid, 0);
    chk("midrst pixel_out", pixel_out, 0);
    chk("midrst de_out", de_out, 0);
    for (int y = 3; y < 6; y++) begin
      for (int x = (y == 3) ? 1 : 0; x < 8; x++) begin
        step(1'b1, 1'b0, 1'b0, in_pix(x, y));
        chk($sformatf("after rst pass(%0d,%0d)", x, y), pixel_out, in_pix(x, y));
      end
      step(1'b0, 1'b1, 1'b0, 24'h0);
      step(1'b0, 1'b1, 1'b0, 24'h0);
    end
    vsync_pulse();
    check_box("f8 discard", 0, 0, 0, 0, 0);

    // Frame 9: first full frame after the reset
    clear_fg(); fg_r[2][1] = 8'hF0; fg_r[3][4] = 8'h90;
    run_frame(1'b0);
    check_frame("f9", 0, 0, 0, 0, 0);
    vsync_pulse();
    check_box("f9 latch", 1, 1, 4, 2, 3);

    // Frame 10: last foreground pixel shares its cycle with the v_sync rise
    clear_fg(); fg_r[2][3] = 8'hA0; fg_r[5][7] = 8'hFF;
    run_frame(1'b1);
    check_frame("f10", 1, 1, 4, 2, 3);
    check_box("f10 coincide", 1, 3, 7, 2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
